bcd_counter_display: RTL

BCD_COUNTER_DISPLAY -- requirements
Module: bcd_counter_display

---
 rtl/bcd_counter_display.sv | 111 +++++++++++
 1 files changed

// File: rtl/bcd_counter_display.sv
// Four-digit BCD up-counter with a multiplexed seven-segment scan driver.
// The count advances on en, clears on clr, and wraps 9999 -> 0000 with a
// one-cycle carry_out pulse. The scan side free-runs: every SCAN_DIV cycles it
// selects the next digit on an, and seg shows the decode of that digit.
module bcd_counter_display #(
    parameter int SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    output logic [15:0] bcd,
    output logic        carry_out,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);

    logic [15:0] bcd_q,   bcd_d;
    logic        carry_q, carry_d;
    logic [15:0] presc_q, presc_d;
    logic [1:0]  idx_q,   idx_d;
    logic [3:0]  an_q,    an_d;

    logic        lower_nines;
    logic [3:0]  digit_sel;

    // Next count: clr wins over en; each digit steps only when all lower digits are 9.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
        bcd_d       = bcd_q;
        carry_d     = 1'b0;
        lower_nines = 1'b1;
        if (clr) begin
            bcd_d = '0;
        end else if (en) begin
            for (int k = 0; k < 4; k++) begin
                if (lower_nines) begin
                    // A 9, or any out-of-range code, rolls over to 0.
                    bcd_d[k*4 +: 4] = (bcd_q[k*4 +: 4] >= 4'd9) ? 4'd0 : bcd_q[k*4 +: 4] + 4'd1;
                end
                lower_nines = lower_nines && (bcd_q[k*4 +: 4] == 4'd9);
            end
            // All four digits were 9: this edge is the 9999 -> 0000 wrap.
            carry_d = lower_nines;
        end
    end

    // Next scan state: prescaler free-runs and advances the digit index on its terminal count.
    always_comb begin
        presc_d = presc_q + 16'd1;
        idx_d   = idx_q;
        if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end
        an_d = 4'b0001 << idx_d;
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (rst) begin
            bcd_q   <= '0;
            carry_q <= 1'b0;
            presc_q <= '0;
            idx_q   <= '0;
            an_q    <= 4'b0001;
        end else begin
            bcd_q   <= bcd_d;
            carry_q <= carry_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
        end
    end

    // Pick the digit that the registered anode select is currently lighting.
    always_comb begin
        case (an_q)
            4'b0001: digit_sel = bcd_q[3:0];
            4'b0010: digit_sel = bcd_q[7:4];
            4'b0100: digit_sel = bcd_q[11:8];
            4'b1000: digit_sel = bcd_q[15:12];
            default: digit_sel = bcd_q[3:0];
        endcase
    end

    // Seven-segment decode {a,b,c,d,e,f,g}; non-decimal codes show a lone dash.
    always_comb begin
        case (digit_sel)
            4'd0:    seg = 7'h7E;
            4'd1:    seg = 7'h30;
            4'd2:    seg = 7'h6D;
            4'd3:    seg = 7'h79;
            4'd4:    seg = 7'h33;
            4'd5:    seg = 7'h5B;
            4'd6:    seg = 7'h5F;
            4'd7:    seg = 7'h70;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h7B;
            default: seg = 7'h01;
        endcase
    end

    assign bcd       = bcd_q;
    assign carry_out = carry_q;
    assign an        = an_q;

endmodule
